// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding, default width and counter sizing for the shift-add multiplier control unit
package mul_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/mul_seq_cu_if.sv
// mul_seq_cu_if: requester/datapath <-> control unit bundle
//   master: requester + datapath side (drives start, b_lsb, b_nz)
//   slave : control unit side (drives ld_a, ld_b, clr_p, ld_p, sh_ab, busy, done)
interface mul_seq_cu_if;
    logic start, b_lsb, b_nz;
    logic ld_a, ld_b, clr_p, ld_p, sh_ab, busy, done;
    modport master (output start, b_lsb, b_nz,
                    input  ld_a, ld_b, clr_p, ld_p, sh_ab, busy, done);
    modport slave  (input  start, b_lsb, b_nz,
                    output ld_a, ld_b, clr_p, ld_p, sh_ab, busy, done);
endinterface

// File: rtl/mul_iter_cnt.sv
// mul_iter_cnt: loadable iteration down-counter; ports clk, rst (async high), load (count<=WIDTH), dec (count-1, saturates at 0), last (count==1)
module mul_iter_cnt
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] INIT = CW'(WIDTH);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= INIT;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end
    assign last = cnt == CW'(1);
endmodule

// File: rtl/mul_seq_cu.sv
// mul_seq_cu: Moore control unit sequencing load/add/shift for a shift-add multiplier
//   ports: clk, rst (async active-high), bus (mul_seq_cu_if.slave: start/b_lsb/b_nz in,
//   ld_a/ld_b/clr_p/ld_p/sh_ab/busy/done out, all registered)
//   optional: define MUL_EARLY_EXIT_EN to finish as soon as B becomes zero in TEST
module mul_seq_cu
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic          clk,
    input logic          rst,
    mul_seq_cu_if.slave  bus
);
    state_t st, nxt;
    logic last;
    mul_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (st == LOAD),
        .dec  (st == SHIFT),
        .last (last)
    );
`ifdef MUL_EARLY_EXIT_EN
    // With B already zero no further adds can occur, so the product is final
    logic test_done;
    assign test_done = !bus.b_nz;
`else
    logic test_done, unused_b_nz;
    assign test_done = 1'b0;
    assign unused_b_nz = bus.b_nz;
`endif
    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:    nxt = bus.start ? LOAD : IDLE;
            LOAD:    nxt = TEST;
            TEST:    nxt = test_done ? DONE : bus.b_lsb ? ADD : SHIFT;
            ADD:     nxt = SHIFT;
            SHIFT:   nxt = last ? DONE : TEST;
            DONE:    nxt = bus.start ? DONE : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            bus.ld_a  <= 1'b0;
            bus.ld_b  <= 1'b0;
            bus.clr_p <= 1'b0;
            bus.ld_p  <= 1'b0;
            bus.sh_ab <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            st        <= nxt;
            bus.ld_a  <= nxt == LOAD;
            bus.ld_b  <= nxt == LOAD;
            bus.clr_p <= nxt == LOAD;
            bus.ld_p  <= nxt == ADD;
            bus.sh_ab <= nxt == SHIFT;
            bus.busy  <= nxt != IDLE;
            bus.done  <= nxt == DONE;
        end
    end
endmodule

// File: tb/tb_mul_seq_cu.sv
// tb_mul_seq_cu: directed bench for mul_seq_cu with behavioural datapath models (WIDTH=4 and WIDTH=8)
module tb_mul_seq_cu;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    logic clr = 1'b0;
    int checks = 0;
    int errors = 0;
    int opa4 = 0, opb4 = 0, opa8 = 0, opb8 = 0;
    logic [15:0] a4 = '0, p4 = '0, a8 = '0, p8 = '0;
    logic [7:0]  b4 = '0, b8 = '0;
    int nlp4 = 0, nsh4 = 0, nlp8 = 0, nsh8 = 0;

    mul_seq_cu_if if4 ();
    mul_seq_cu_if if8 ();
    mul_seq_cu #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    mul_seq_cu #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    always #5 clk = ~clk;

    assign if4.b_lsb = b4[0];
    assign if4.b_nz  = |b4;
    assign if8.b_lsb = b8[0];
    assign if8.b_nz  = |b8;

    always @(posedge clk) begin
        if (if4.ld_a) a4 <= 16'(opa4);
        if (if4.ld_b) b4 <= 8'(opb4);
        if (if4.clr_p) p4 <= '0;
        if (if4.ld_p) p4 <= p4 + a4;
        if (if4.sh_ab) begin a4 <= a4 << 1; b4 <= b4 >> 1; end
        if (if8.ld_a) a8 <= 16'(opa8);
        if (if8.ld_b) b8 <= 8'(opb8);
        if (if8.clr_p) p8 <= '0;
        if (if8.ld_p) p8 <= p8 + a8;
        if (if8.sh_ab) begin a8 <= a8 << 1; b8 <= b8 >> 1; end
        if (clr) begin
            nlp4 <= 0; nsh4 <= 0; nlp8 <= 0; nsh8 <= 0;
        end else begin
            nlp4 <= nlp4 + int'(if4.ld_p); nsh4 <= nsh4 + int'(if4.sh_ab);
            nlp8 <= nlp8 + int'(if8.ld_p); nsh8 <= nsh8 + int'(if8.sh_ab);
        end
    end

    function automatic int outs(input bit w8);
        return w8 ? int'({if8.ld_a, if8.ld_b, if8.clr_p, if8.ld_p, if8.sh_ab, if8.busy, if8.done})
                  : int'({if4.ld_a, if4.ld_b, if4.clr_p, if4.ld_p, if4.sh_ab, if4.busy, if4.done});
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise start and count edges (edge 1 samples start) until done; 100-edge bound
    task automatic run(input bit w8, input int a, input int b, output int edges);
        edges = 0;
        if (w8) begin opa8 = a; opb8 = b; if8.start = 1'b1; end
        else begin opa4 = a; opb4 = b; if4.start = 1'b1; end
        clr = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            edges++;
            clr = 1'b0;
            if (w8 ? if8.done : if4.done) break;
        end
        chk("done_no_strobe", outs(w8) & 7'b1111100, 0);
    endtask

    task automatic drop4();
        if4.start = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", int'(if4.busy), 0);
        chk("idle_done", int'(if4.done), 0);
    endtask

    initial begin
        int e;
        bit found;
        rst = 1'b0;
        if4.start = 1'b0;
        if8.start = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs4", outs(1'b0), 0);
        chk("rst_outs8", outs(1'b1), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(1'b0, 5, 3, e);
        chk("5x3_edges", e, EE ? 9 : 12);
        chk("5x3_p", int'(p4), 15);
        chk("5x3_ldp", nlp4, 2);
        chk("5x3_sh", nsh4, EE ? 2 : 4);
        drop4();

        run(1'b0, 5, 0, e);
        chk("5x0_edges", e, EE ? 3 : 10);
        chk("5x0_p", int'(p4), 0);
        chk("5x0_ldp", nlp4, 0);
        chk("5x0_sh", nsh4, EE ? 0 : 4);
        drop4();

        run(1'b0, 5, 5, e);
        chk("5x5_edges", e, EE ? 11 : 12);
        chk("5x5_p", int'(p4), 25);
        chk("5x5_ldp", nlp4, 2);
        chk("5x5_sh", nsh4, EE ? 3 : 4);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_done", int'(if4.done), 1);
            chk("hold_no_load", int'(if4.ld_a), 0);
        end
        drop4();
        if4.start = 1'b1;
        @(posedge clk); #1;
        chk("restart_load", int'(if4.ld_a), 1);
        if4.start = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            found = if4.ld_p;
        end
        chk("reach_add", int'(found), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_outs", outs(1'b0), 0);
        chk("abort_busy", int'(if4.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_outs", outs(1'b0), 0);

        run(1'b1, 7, 9, e);
        chk("7x9_edges", e, EE ? 13 : 20);
        chk("7x9_p", int'(p8), 63);
        chk("7x9_ldp", nlp8, 2);
        chk("7x9_sh", nsh8, EE ? 4 : 8);
        if8.start = 1'b0;
        @(posedge clk); #1;
        chk("7x9_idle", int'(if8.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
